// File: rtl/run_ctrl_pkg.sv
// Shared types, defaults and helpers for the run controller slice.
// Build option: RUN_CTRL_CPI_EN adds retired-instruction and stall counters.
package run_ctrl_pkg;

   localparam int DEF_PC_W         = 32;
   localparam int DEF_CNT_W        = 32;
   localparam int DEF_RESET_CYCLES = 4;
   localparam int DEF_HALT_WINDOW  = 8;
   localparam int DEF_MAX_CYCLES   = 250;

   // Widest counter the saturating helper supports.
   localparam int SAT_W = 64;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RESET_CORE = 3'd1,
      RUN        = 3'd2,
      DONE       = 3'd3,
      TIMEOUT    = 3'd4
   } state_t;

   // Increment a width-bit value held in SAT_W bits, sticking at all-ones.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                input int unsigned       width);
      logic [SAT_W-1:0] max_val;
      max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
      return (value >= max_val) ? value : value + SAT_W'(1);
   endfunction

endpackage

// File: rtl/pc_stable_detector.sv
// Counts consecutive RUN cycles with an unchanged fetch PC and flags a halt
// once the run length reaches HALT_WINDOW.
module pc_stable_detector
   import run_ctrl_pkg::*;
#(
   parameter int PC_W        = DEF_PC_W,
   parameter int HALT_WINDOW = DEF_HALT_WINDOW
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   input  logic [PC_W-1:0] pc,
   output logic            stable
);

   localparam int SW = $clog2(HALT_WINDOW + 1);

   logic [PC_W-1:0] prev_pc;
   logic            prev_valid;
   logic [SW-1:0]   count;
   logic [SW-1:0]   count_next;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_next = SW'(1);
      if (prev_valid && (pc == prev_pc))
         count_next = (count >= SW'(HALT_WINDOW)) ? count : count + SW'(1);
   end

   // Looks at this cycle's count so the halt lands on the HALT_WINDOW-th cycle.
   assign stable = enable && (count_next >= SW'(HALT_WINDOW));

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         count      <= '0;
      end else if (enable) begin
         prev_pc    <= pc;
         prev_valid <= 1'b1;
         count      <= count_next;
      end
   end

endmodule

// File: rtl/run_controller.sv
// Run controller: sequences core reset, counts RUN cycles and ends the run on
// halt, stalled PC or timeout. Build option: RUN_CTRL_CPI_EN adds CPI counters.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int PC_W         = DEF_PC_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int HALT_WINDOW  = DEF_HALT_WINDOW,
   parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_req,
   input  logic [PC_W-1:0]  pc,
   input  logic             retire,
   output logic             core_reset,
   output logic             running,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_count
`ifdef RUN_CTRL_CPI_EN
   ,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
`endif
);

   localparam int RC_W = $clog2(RESET_CYCLES + 1);

   state_t          state;
   state_t          next_state;
   logic [RC_W-1:0] rc_cnt;
   logic            stable;
   logic            halt_hit;
   logic            timeout_hit;
   logic            entering_reset;

   pc_stable_detector #(
      .PC_W        (PC_W),
      .HALT_WINDOW (HALT_WINDOW)
   ) u_stable (
      .clock  (clock),
      .reset  (reset),
      .clear  (state == RESET_CORE),
      .enable (state == RUN),
      .pc     (pc),
      .stable (stable)
   );

   assign halt_hit       = halt_req || stable;
   assign timeout_hit    = (SAT_W'(cycle_count) == SAT_W'(MAX_CYCLES - 1));
   assign entering_reset = (next_state == RESET_CORE) && (state != RESET_CORE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Halt is checked first so a simultaneous timeout resolves to DONE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:          if (start) next_state = RESET_CORE;
         RESET_CORE:    if (rc_cnt == RC_W'(RESET_CYCLES - 1)) next_state = RUN;
         RUN: begin
            if (halt_hit)         next_state = DONE;
            else if (timeout_hit) next_state = TIMEOUT;
         end
         DONE, TIMEOUT: if (start) next_state = RESET_CORE;
         default:       next_state = IDLE;
      endcase
   end

   always_comb begin
      core_reset = 1'b0;
      running    = 1'b0;
      done       = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE, RESET_CORE: core_reset = 1'b1;
         RUN:              running    = 1'b1;
         DONE:             done       = 1'b1;
         TIMEOUT:          timed_out  = 1'b1;
         default:          core_reset = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || entering_reset) begin
         rc_cnt      <= '0;
         cycle_count <= '0;
      end else begin
         if (state == RESET_CORE) rc_cnt <= rc_cnt + RC_W'(1);
         if (state == RUN) cycle_count <= CNT_W'(sat_inc(SAT_W'(cycle_count), CNT_W));
      end
   end

`ifdef RUN_CTRL_CPI_EN
   always_ff @(posedge clock) begin
      if (reset || entering_reset) begin
         instr_count <= '0;
         stall_count <= '0;
      end else if (state == RUN) begin
         if (retire) instr_count <= CNT_W'(sat_inc(SAT_W'(instr_count), CNT_W));
         else        stall_count <= CNT_W'(sat_inc(SAT_W'(stall_count), CNT_W));
      end
   end
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: sequencing, halts, timeout, saturation,
// restart and mid-run reset. CPI checks are active with RUN_CTRL_CPI_EN.
module tb_run_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        retire = 1'b0;
   logic [31:0] pc = 32'h0;

   logic        core_reset, running, done, timed_out;
   logic [31:0] cycle_count;
   logic        core_reset2, running2, done2, timed_out2;
   logic [7:0]  cycle_count2;
`ifdef RUN_CTRL_CPI_EN
   logic [31:0] instr_count, stall_count;
   logic [7:0]  instr_count2, stall_count2;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   run_controller dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .halt_req    (halt_req),
      .pc          (pc),
      .retire      (retire),
      .core_reset  (core_reset),
      .running     (running),
      .done        (done),
      .timed_out   (timed_out),
      .cycle_count (cycle_count)
`ifdef RUN_CTRL_CPI_EN
      ,
      .instr_count (instr_count),
      .stall_count (stall_count)
`endif
   );

   // Narrow counters and a long budget so cycle_count saturates at 255.
   run_controller #(.CNT_W(8), .MAX_CYCLES(1000)) dut_sat (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .halt_req    (halt_req),
      .pc          (pc),
      .retire      (retire),
      .core_reset  (core_reset2),
      .running     (running2),
      .done        (done2),
      .timed_out   (timed_out2),
      .cycle_count (cycle_count2)
`ifdef RUN_CTRL_CPI_EN
      ,
      .instr_count (instr_count2),
      .stall_count (stall_count2)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Start pulse plus four RESET_CORE cycles; returns at the start of RUN cycle 1.
   task automatic begin_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
   endtask

   task automatic run_cycles(input int first, input int last, input logic [31:0] base);
      for (int k = first; k <= last; k++) begin
         pc = base + 32'(4 * k);
         tick();
      end
   endtask

   initial begin
      // Reset state and core reset sequencing
      repeat (2) tick();
      reset = 1'b0;
      check("rst_core_reset", core_reset, 1);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_timed_out", timed_out, 0);
      check("rst_cycle_count", cycle_count, 0);
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("seq_core_reset_high", core_reset, 1);
         check("seq_not_running", running, 0);
         tick();
      end
      check("seq_running_rise", running, 1);
      check("seq_core_reset_low", core_reset, 0);
      check("seq_count_zero", cycle_count, 0);

      // Explicit halt on RUN cycle 20
      run_cycles(1, 19, 32'h1000);
      check("halt_pre_running", running, 1);
      check("halt_pre_count", cycle_count, 19);
      pc = 32'h1050;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("halt_done", done, 1);
      check("halt_count", cycle_count, 20);
      check("halt_core_reset", core_reset, 0);
      check("halt_timed_out", timed_out, 0);
      check("halt_sat_count", cycle_count2, 20);
      run_cycles(21, 23, 32'h1000);
      check("halt_sticky", done, 1);
      check("halt_frozen", cycle_count, 20);

      // Restart from DONE clears counters and re-enters RESET_CORE
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_core_reset", core_reset, 1);
      check("restart_done_clear", done, 0);
      check("restart_count_zero", cycle_count, 0);
      repeat (4) tick();
      check("restart_running", running, 1);

      // PC held at 0x40 from RUN cycle 10 halts on RUN cycle 17
      run_cycles(1, 9, 32'h2000);
      for (int k = 10; k <= 16; k++) begin
         pc = 32'h40;
         tick();
      end
      check("stall_pre_running", running, 1);
      tick();
      check("stall_done", done, 1);
      check("stall_timed_out", timed_out, 0);
      check("stall_count", cycle_count, 17);

      // Timeout after 250 RUN cycles; narrow instance saturates meanwhile
      begin_run();
      run_cycles(1, 249, 32'h3000);
      check("to_pre_running", running, 1);
      check("to_pre_count", cycle_count, 249);
      run_cycles(250, 250, 32'h3000);
      check("to_timed_out", timed_out, 1);
      check("to_done", done, 0);
      check("to_count", cycle_count, 250);
      run_cycles(251, 260, 32'h3000);
      check("to_frozen", cycle_count, 250);
      check("sat_running", running2, 1);
      check("sat_count", cycle_count2, 255);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("to_halt_ignored_done", done, 0);
      check("to_halt_ignored_to", timed_out, 1);
      check("sat_done", done2, 1);
      check("sat_frozen", cycle_count2, 255);

      // Halt and timeout in the same cycle resolve to DONE
      begin_run();
      run_cycles(1, 249, 32'h4000);
      pc = 32'h4400;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("tie_done", done, 1);
      check("tie_timed_out", timed_out, 0);
      check("tie_count", cycle_count, 250);

      // retire every other cycle; retire in IDLE and RESET_CORE is ignored
      reset = 1'b1;
      tick();
      reset = 1'b0;
      retire = 1'b1;
      repeat (3) tick();
      begin_run();
      for (int k = 1; k <= 100; k++) begin
         pc = 32'h5000 + 32'(4 * k);
         retire = k[0];
         halt_req = (k == 100);
         tick();
      end
      halt_req = 1'b0;
      retire = 1'b0;
      check("cpi_done", done, 1);
      check("cpi_cycles", cycle_count, 100);
`ifdef RUN_CTRL_CPI_EN
      check("cpi_instr", instr_count, 50);
      check("cpi_stall", stall_count, 50);
      check("cpi_sat_instr", instr_count2, 50);
`endif

      // Mid-run reset on RUN cycle 30, with a simultaneous start ignored
      begin_run();
      run_cycles(1, 29, 32'h6000);
      check("mid_pre_count", cycle_count, 29);
      reset = 1'b1;
      start = 1'b1;
      retire = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      retire = 1'b0;
      check("mid_core_reset", core_reset, 1);
      check("mid_running", running, 0);
      check("mid_count", cycle_count, 0);
`ifdef RUN_CTRL_CPI_EN
      check("mid_instr", instr_count, 0);
      check("mid_stall", stall_count, 0);
`endif
      tick();
      check("mid_idle_core_reset", core_reset, 1);
      check("mid_idle_not_running", running, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/run_controller.md
# run_controller

Cycle-accurate run controller placed between the bench clock/reset and the pipelined processor `Wrapper`. It sequences core reset, counts cycles and retired instructions, and ends the run on a halt request, a stalled PC or a timeout. It replaces a fixed-delay `$finish` with a parametrised, status-reporting controller that both benches and FPGA debug builds can use.

## Interface
- `PC_W`, 32: width of the monitored program counter.
- `CNT_W`, 32: width of all counters.
- `RESET_CYCLES`, 4: number of cycles `core_reset` is held in RESET_CORE; must be ≥1.
- `HALT_WINDOW`, 8: number of consecutive unchanged-PC cycles that counts as a halt; must be ≥2.
- `MAX_CYCLES`, 250: RUN-cycle budget before timeout; must be ≥1.

- `clock` in 1: single clock for all logic; everything samples on the rising edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: single-cycle pulse that begins a run; sampled in IDLE, DONE and TIMEOUT.
- `halt_req` in 1: explicit halt from the core, valid only in RUN.
- `pc` in PC_W: core fetch PC.
- `retire` in 1: one instruction retired this cycle.
- `core_reset` out 1: reset to the processor, active-high.
- `running` out 1: high while in RUN.
- `done` out 1: high while in DONE; sticky.
- `timed_out` out 1: high while in TIMEOUT; sticky.
- `cycle_count` out CNT_W: number of RUN cycles elapsed.
- `instr_count` out CNT_W: number of retired instructions; only present with `RUN_CTRL_CPI_EN`.
- `stall_count` out CNT_W: number of RUN cycles with `retire`=0; only present with `RUN_CTRL_CPI_EN`.

## Operation
- States: IDLE, RESET_CORE, RUN, DONE, TIMEOUT.
- Transitions:
  - IDLE →(`start`) RESET_CORE.
  - RESET_CORE → RUN after exactly RESET_CYCLES cycles in RESET_CORE.
  - RUN → DONE on `halt_req`, or when the PC-stable count reaches HALT_WINDOW.
  - RUN → TIMEOUT when `cycle_count` = MAX_CYCLES−1 and no halt condition is present in the same cycle.
  - DONE/TIMEOUT →(`start`) RESET_CORE.
  - Any other (state, input) combination holds the current state.
- `core_reset` is 1 in IDLE and RESET_CORE, and 0 elsewhere.
- Halt and timeout in the same cycle resolve to DONE.
- PC-stable counter:
  - Cleared on entering RUN.
  - Increments when `pc` equals the previous cycle's `pc`; otherwise resets to 1.
  - The first RUN cycle loads the previous-PC register and counts as 1.
- Counters:
  - Cleared on the RESET_CORE entry cycle.
  - Increment only in RUN.
  - Saturate at all-ones, never wrap.
  - Frozen in DONE and TIMEOUT until the next `start`.
- `retire` and `halt_req` are ignored outside RUN.

## Timing
- Reset values: state IDLE, `core_reset`=1, `running`=0, `done`=0, `timed_out`=0, all counts 0.
- `start` at cycle t puts RESET_CORE in effect at t+1. RUN begins at t+1+RESET_CYCLES, with `core_reset` falling in that same cycle.
- Status outputs and counts are registered and reflect the state after the edge, so there is no combinational path from inputs to outputs.
- `halt_req` sampled high at edge e sets `done` high after e; `cycle_count` includes the halting cycle.
- Asserting `reset` mid-run gives IDLE on the next edge, with all counters zeroed and `core_reset`=1. A `start` in the same cycle as `reset` is ignored.

## Configuration
- `RUN_CTRL_CPI_EN` defined: the `instr_count` and `stall_count` registers and ports exist.
- `RUN_CTRL_CPI_EN` undefined: those ports and registers are absent, and `retire` is unused.
- State machine and `cycle_count` behaviour is identical in both builds.

## Structure
- Package `run_ctrl_pkg` holds:
  - The state enum (IDLE=0, RESET_CORE=1, RUN=2, DONE=3, TIMEOUT=4), 3 bits wide.
  - Default parameter constants.
  - A saturating-increment function.
- One sub-module, `pc_stable_detector`:
  - Inputs: `clock`, `reset`, `clear`, `enable`, `pc`.
  - Output: `stable`, asserted when the count ≥ HALT_WINDOW.
  - Parameters: `PC_W`, `HALT_WINDOW`.

## Test plan
- Reset sequencing: reset, then `start` at cycle 5 → `core_reset` is high for cycles 6–9 (RESET_CYCLES=4), `running` rises at cycle 10.
- Explicit halt: in RUN with `pc` incrementing by 4 each cycle, assert `halt_req` on RUN cycle 20 → `done`=1, `cycle_count`=20, `core_reset` stays 0.
- PC stall: `pc` held at 0x40 from RUN cycle 10, HALT_WINDOW=8 → `done` on RUN cycle 17, `timed_out`=0.
- Timeout and tie-break: MAX_CYCLES=250 with an advancing `pc` → `timed_out` with `cycle_count`=250. Repeat with `halt_req` on RUN cycle 250 → `done`=1, `timed_out`=0.
- CPI counts (`RUN_CTRL_CPI_EN`): `retire` every other cycle for 100 RUN cycles, then halt → `instr_count`=50, `stall_count`=50. `retire` asserted in IDLE is not counted.
- Restart and mid-run reset: `start` in DONE → counters 0 and RESET_CORE re-entered. `reset` on RUN cycle 30 → IDLE, `core_reset`=1 and all counts 0 on the next edge.
